// File: rtl/reduce_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reduce_pkg : op/state encodings and fold helpers shared by reduce_accum
// Rev 1.0
// ---------------------------------------------------------------------------
package reduce_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ACC  = 2'b01,
      S_HOLD = 2'b10
   } state_t;

   // Reserved op 2'b11 folds like AND, so its identity is 1 as well.
   function automatic logic op_identity(input logic [1:0] op);
      return !((op == OP_OR) || (op == OP_XOR));
   endfunction

   function automatic logic op_combine(input logic [1:0] op, input logic a, input logic b);
      case (op)
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return a & b;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/reduce_word.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reduce_word : combinational AND/OR/XOR reduction of one beat to one bit
// Rev 1.0
// ---------------------------------------------------------------------------
module reduce_word
   import reduce_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       op,
   output logic             red
);

   always_comb begin
      case (op)
         OP_OR:   red = |data;
         OP_XOR:  red = ^data;
         default: red = &data;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/reduce_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reduce_accum : folds framed beats into one result bit on a valid/ready port
// Rev 1.0
// ---------------------------------------------------------------------------
module reduce_accum
   import reduce_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int MAX_BEATS = 16,
   localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic [1:0]       op,
   input  logic             invert,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic [CNT_W-1:0] out_beats,
   output logic             out_overflow
);

   state_t           state_q, state_d;
   logic             acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             inv_q, inv_d;
   logic             out_valid_q, out_valid_d;
   logic             out_bit_q, out_bit_d;
   logic [CNT_W-1:0] out_beats_q, out_beats_d;
   logic             out_overflow_q, out_overflow_d;

   logic [1:0]       w_op_eff;
   logic             w_word_red;
   logic             w_accept;
   logic [CNT_W-1:0] w_cnt_next;

   // The first beat of a frame reduces under the live op, later beats under the latched one.
   assign w_op_eff = (state_q == S_IDLE) ? op : op_q;

   reduce_word #(
      .WIDTH (WIDTH)
   ) u_word (
      .data (in_data),
      .op   (w_op_eff),
      .red  (w_word_red)
   );

   assign in_ready   = rst_n && (state_q != S_HOLD);
   assign w_accept   = in_valid && in_ready;
   assign w_cnt_next = cnt_q + CNT_W'(1);

   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      cnt_d          = cnt_q;
      op_d           = op_q;
      inv_d          = inv_q;
      out_valid_d    = out_valid_q;
      out_bit_d      = out_bit_q;
      out_beats_d    = out_beats_q;
      out_overflow_d = out_overflow_q;

      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               op_d  = op;
               inv_d = invert;
               acc_d = op_combine(op, op_identity(op), w_word_red);
               cnt_d = CNT_W'(1);
               if (in_last || (MAX_BEATS == 1)) begin
                  state_d        = S_HOLD;
                  out_valid_d    = 1'b1;
                  out_bit_d      = acc_d ^ invert;
                  out_beats_d    = CNT_W'(1);
                  out_overflow_d = !in_last;
               end else begin
                  state_d = S_ACC;
               end
            end
         end
         S_ACC: begin
            if (w_accept) begin
               acc_d = op_combine(op_q, acc_q, w_word_red);
               cnt_d = w_cnt_next;
               if (in_last || (w_cnt_next == CNT_W'(MAX_BEATS))) begin
                  state_d        = S_HOLD;
                  out_valid_d    = 1'b1;
                  out_bit_d      = acc_d ^ inv_q;
                  out_beats_d    = w_cnt_next;
                  out_overflow_d = !in_last;
               end
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         acc_q          <= 1'b0;
         cnt_q          <= '0;
         op_q           <= 2'b00;
         inv_q          <= 1'b0;
         out_valid_q    <= 1'b0;
         out_bit_q      <= 1'b0;
         out_beats_q    <= '0;
         out_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         cnt_q          <= cnt_d;
         op_q           <= op_d;
         inv_q          <= inv_d;
         out_valid_q    <= out_valid_d;
         out_bit_q      <= out_bit_d;
         out_beats_q    <= out_beats_d;
         out_overflow_q <= out_overflow_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_bit      = out_bit_q;
   assign out_beats    = out_beats_q;
   assign out_overflow = out_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_reduce_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reduce_accum : directed + random frames against a frame-level reference
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_reduce_accum;

   localparam int WIDTH     = 3;
   localparam int MAX_BEATS = 4;
   localparam int CNT_W     = $clog2(MAX_BEATS + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic [1:0]       op = 2'b00;
   logic             invert = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_bit;
   logic [CNT_W-1:0] out_beats;
   logic             out_overflow;

   reduce_accum #(
      .WIDTH     (WIDTH),
      .MAX_BEATS (MAX_BEATS)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .op           (op),
      .invert       (invert),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_bit      (out_bit),
      .out_beats    (out_beats),
      .out_overflow (out_overflow)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: whole frames are collected, then scored by counting beats whose reduction is 1.
   typedef struct {
      logic b;
      int   n;
      logic ovf;
   } exp_t;

   exp_t             exp_q[$];
   logic [WIDTH-1:0] frame_q[$];
   logic [1:0]       frame_op;
   logic             frame_inv;

   function automatic logic beat_red(input logic [1:0] o, input logic [WIDTH-1:0] w);
      case (o)
         2'b01:   return |w;
         2'b10:   return ^w;
         default: return &w;
      endcase
   endfunction

   task automatic model_accept(input logic [WIDTH-1:0] d, input logic last,
                               input logic [1:0] o, input logic inv);
      int   ones;
      exp_t e;
      if (frame_q.size() == 0) begin
         frame_op  = o;
         frame_inv = inv;
      end
      frame_q.push_back(d);
      if (last || frame_q.size() == MAX_BEATS) begin
         ones = 0;
         foreach (frame_q[i]) if (beat_red(frame_op, frame_q[i])) ones++;
         case (frame_op)
            2'b01:   e.b = (ones > 0);
            2'b10:   e.b = ones[0];
            default: e.b = (ones == frame_q.size());
         endcase
         e.b   = e.b ^ frame_inv;
         e.n   = frame_q.size();
         e.ovf = !last;
         exp_q.push_back(e);
         frame_q.delete();
      end
   endtask

   task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic last,
                        input logic [1:0] o, input logic inv, input logic ordy,
                        output bit took);
      bit pending;
      in_valid  = v;
      in_data   = d;
      in_last   = last;
      op        = o;
      invert    = inv;
      out_ready = ordy;
      took      = 1'b0;
      @(negedge clk);
      pending = (exp_q.size() != 0);
      check_eq("out_valid", out_valid, pending);
      check_eq("in_ready", in_ready, !pending);
      if (pending) begin
         check_eq("out_bit", out_bit, exp_q[0].b);
         check_eq("out_beats", out_beats, exp_q[0].n);
         check_eq("out_overflow", out_overflow, exp_q[0].ovf);
         if (ordy) void'(exp_q.pop_front());
      end else if (v) begin
         model_accept(d, last, o, inv);
         took = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] d, input logic last,
                       input logic [1:0] o, input logic inv);
      bit took;
      int tries = 0;
      do begin
         cycle(1'b1, d, last, o, inv, 1'b1, took);
         tries++;
      end while (!took && tries < 16);
      check_eq("send_accept", took, 1);
   endtask

   task automatic idle(input int n);
      bit took;
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b1, took);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check_eq("rst_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_bit", out_bit, 0);
      check_eq("rst_out_beats", out_beats, 0);
      check_eq("rst_out_overflow", out_overflow, 0);
      exp_q.delete();
      frame_q.delete();
      rst_n = 1'b1;
   endtask

   initial begin
      bit took;
      do_reset();

      // single AND beat
      send(3'b111, 1'b1, 2'b00, 1'b0);
      idle(2);
      // multi-beat AND, then OR
      send(3'b111, 1'b0, 2'b00, 1'b0);
      send(3'b111, 1'b0, 2'b00, 1'b0);
      send(3'b010, 1'b1, 2'b00, 1'b0);
      idle(2);
      send(3'b000, 1'b0, 2'b01, 1'b0);
      send(3'b000, 1'b0, 2'b01, 1'b0);
      send(3'b100, 1'b1, 2'b01, 1'b0);
      idle(2);
      // XNOR, with op/invert wiggled mid-frame
      send(3'b001, 1'b0, 2'b10, 1'b1);
      send(3'b011, 1'b0, 2'b00, 1'b0);
      send(3'b111, 1'b1, 2'b01, 1'b0);
      idle(2);
      // backpressure with a beat waiting
      send(3'b111, 1'b1, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 3'b101, 1'b1, 2'b01, 1'b0, 1'b0, took);
      send(3'b101, 1'b1, 2'b01, 1'b0);
      idle(2);
      // forced termination; fifth beat opens the next frame
      for (int i = 0; i < 5; i++) send(3'b111, 1'b0, 2'b00, 1'b0);
      send(3'b110, 1'b1, 2'b00, 1'b0);
      idle(2);
      // last coinciding with the count limit
      for (int i = 0; i < 3; i++) send(3'b001, 1'b0, 2'b10, 1'b0);
      send(3'b001, 1'b1, 2'b10, 1'b0);
      idle(2);
      // reset mid-frame discards it
      send(3'b111, 1'b0, 2'b00, 1'b0);
      send(3'b111, 1'b0, 2'b00, 1'b0);
      do_reset();
      send(3'b011, 1'b1, 2'b00, 1'b0);
      idle(2);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            cycle(1'($urandom_range(0, 9) < 7), WIDTH'($urandom), 1'($urandom_range(0, 3) == 0),
                  2'($urandom), 1'($urandom), 1'($urandom_range(0, 9) < 6), took);
         end
      end

      idle(6);
      check_eq("drain_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reduce_accum.md
Name: reduce_accum

Overview:
Parametrised, multi-mode streaming reduction unit. Reduces each WIDTH-bit input beat to one bit (AND/OR/XOR), then folds the beats of a frame into a single result bit. The result is presented on a valid/ready output. Used as a sequential test block for flow tracking across framed multi-cycle reductions.

Parameters:
WIDTH, 8, bits per input beat (>=1)
MAX_BEATS, 16, maximum beats per frame before forced termination (>=1)
CNT_W, $clog2(MAX_BEATS+1), width of beat counter/output (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat
in_data  in  WIDTH  beat payload
in_last  in  1  final beat of frame
op  in  2  00=AND, 01=OR, 10=XOR, 11=reserved (treated as AND); sampled on first beat
invert  in  1  invert final result (NAND/NOR/XNOR); sampled on first beat
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_bit  out  1  reduced frame result
out_beats  out  CNT_W  beats folded into result
out_overflow  out  1  frame terminated by MAX_BEATS, not in_last

Behaviour:
- One clock domain (clk). rst_n synchronous, active-low: on a clk edge with rst_n=0, the FSM goes to IDLE and out_valid, out_bit, out_beats, out_overflow, the accumulator, the counter and the latched op/invert all clear to 0. in_ready=0 while rst_n=0.
- Beat accepted iff in_valid && in_ready at a clk edge. Result accepted iff out_valid && out_ready.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On accept: latch op/invert, acc <= identity(op) combined with word_red, cnt <= 1. Go to HOLD if in_last or MAX_BEATS=1, else ACC.
  - ACC: in_ready=1. On accept: acc <= acc op word_red, cnt <= cnt+1. Go to HOLD if in_last or cnt+1==MAX_BEATS.
  - HOLD: in_ready=0, out_valid=1. out_bit, out_beats and out_overflow are registered and stable. On result accept go to IDLE.
- word_red = reduction of in_data under the latched op. On the first beat the live op is used.
- identity: AND=1, OR=0, XOR=0.
- out_bit = final acc ^ invert. out_overflow=1 only when HOLD was entered via the count limit with in_last=0.
- Latency: out_valid rises the cycle after the terminating beat is accepted. No bypass, so the minimum frame period is 2 cycles plus any out_ready stall.
- In HOLD, in_valid is ignored and not consumed. The beat that follows a forced termination starts the next frame.
- op/invert changes mid-frame have no effect until the next frame.
- in_last together with the count limit on the same beat gives out_overflow=0.
- rst_n low mid-frame or in HOLD discards the frame. No out_valid is produced for it.
- Counter never wraps: its maximum is MAX_BEATS.

Decomposition:
- Package reduce_pkg:
  - op encoding constants (OP_AND, OP_OR, OP_XOR)
  - state encoding (S_IDLE, S_ACC, S_HOLD)
  - identity-value function
- Sub-module reduce_word: combinational, parameter WIDTH, inputs data/op, output 1-bit reduction. Instantiated once in reduce_accum. The FSM, accumulator and counter stay in the top.

Test Plan:
1. WIDTH=3, op=00, invert=0; single beat 3'b111 with in_last=1, out_ready=1 -> out_valid one cycle later, out_bit=1, out_beats=1, out_overflow=0.
2. op=00; beats 111, 111, 010 (last on third) -> out_bit=0, out_beats=3. Repeat with op=01 and beats 000, 000, 100 -> out_bit=1.
3. op=10, invert=1; beats 001, 011, 111 -> XOR of per-beat parities (1,0,1)=0, inverted, so out_bit=1, out_beats=3.
4. Backpressure: after frame end hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, no beat consumed, outputs stable. Then out_ready=1 -> IDLE next cycle and the pending beat is accepted.
5. MAX_BEATS=4, stream 5 beats of 111, op=00, in_last never set -> HOLD after 4th beat with out_bit=1, out_beats=4, out_overflow=1. The 5th beat is accepted after the handshake as the first beat of a new frame.
6. rst_n=0 for one edge after the 2nd beat of a frame -> all outputs 0, IDLE. The next frame (011, last; op=00) gives out_bit=0, out_beats=1, unaffected by the discarded frame.
